hd_fifo_stage: RTL

//  Elastic valid/ready buffer directly downstream of the HD_COMPART handshake stage.

---
 rtl/hd_fifo_stage_pkg.sv | 24 ++
 rtl/hd_fifo_stage_if.sv | 46 ++++
 rtl/hd_fifo_mem.sv | 28 ++
 rtl/hd_fifo_stage.sv | 81 ++++++++
 4 files changed

// File: rtl/hd_fifo_stage_pkg.sv
// Shared definitions for the hd_fifo_stage block: default sizes and the
// clog2 helper used to derive pointer widths.
package hd_fifo_stage_pkg;

  // Default payload width shared by the hd_* blocks.
  localparam int HD_DATA_WIDTH = 16;

  // Default number of buffer entries.
  localparam int HD_FIFO_DEPTH = 4;

  // Ceiling log2. Returns 0 for an argument of 0 or 1.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/hd_fifo_stage_if.sv
// Handshake bundle around hd_fifo_stage.
// Valid/ready contract: a word moves across a channel exactly on a rising
// clock edge where both its valid and its ready are high; the sender keeps
// valid and data stable until that edge, and ready may change freely.
// Upstream channel: valid / data_src / ready_output.
// Downstream channel: valid_output / data_dest / ready.
interface hd_fifo_stage_if
  import hd_fifo_stage_pkg::*;
#(
  parameter int DATA_WIDTH = HD_DATA_WIDTH,
  parameter int DEPTH      = HD_FIFO_DEPTH
);

  localparam int CNT_WIDTH = clog2(DEPTH) + 1;

  logic                  valid;
  logic [DATA_WIDTH-1:0] data_src;
  logic                  ready_output;
  logic                  valid_output;
  logic [DATA_WIDTH-1:0] data_dest;
  logic                  ready;
  logic [CNT_WIDTH-1:0]  count;

  // Environment side: producer and consumer.
  modport master (
    output valid,
    output data_src,
    output ready,
    input  ready_output,
    input  valid_output,
    input  data_dest,
    input  count
  );

  // Buffer side.
  modport slave (
    input  valid,
    input  data_src,
    input  ready,
    output ready_output,
    output valid_output,
    output data_dest,
    output count
  );

endinterface

// File: rtl/hd_fifo_mem.sv
// Storage array for hd_fifo_stage: one synchronous write port and an
// asynchronous read port so the head word is visible without a read cycle.
// Contents are intentionally not reset; occupancy lives in the pointers.
module hd_fifo_mem #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Write the accepted upstream word into its slot.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/hd_fifo_stage.sv
// Elastic show-ahead valid/ready buffer. Pointers carry one extra wrap bit so
// full and empty are told apart without a separate flag; occupancy is the
// pointer difference.
module hd_fifo_stage
  import hd_fifo_stage_pkg::*;
#(
  parameter int DATA_WIDTH = HD_DATA_WIDTH,
  parameter int DEPTH      = HD_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  hd_fifo_stage_if.slave   bus
);

  localparam int ADDR_WIDTH = clog2(DEPTH);

  logic [ADDR_WIDTH:0]   r_wr_ptr;
  logic [ADDR_WIDTH:0]   r_rd_ptr;
  logic                  r_accept_en;

  logic                  w_empty;
  logic                  w_full;
  logic                  w_push;
  logic                  w_pop;
  logic [DATA_WIDTH-1:0] w_rdata;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[ADDR_WIDTH] != r_rd_ptr[ADDR_WIDTH]) &&
                   (r_wr_ptr[ADDR_WIDTH-1:0] == r_rd_ptr[ADDR_WIDTH-1:0]);

  // ready_output looks only at state, never at this cycle's pop, so a pop
  // at full opens the slot one cycle later (no combinational pass-through).
  assign w_push = bus.valid && bus.ready_output;
  assign w_pop  = bus.ready && !w_empty;

  // Hold off acceptance until the first edge after reset is released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_accept_en <= 1'b0;
    end else begin
      r_accept_en <= 1'b1;
    end
  end

  // Write pointer advances on every accepted upstream word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
    end else if (w_push) begin
      r_wr_ptr <= r_wr_ptr + 1'b1;
    end
  end

  // Read pointer advances on every word taken by the consumer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
    end else if (w_pop) begin
      r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  hd_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr[ADDR_WIDTH-1:0]),
    .i_wdata (bus.data_src),
    .i_raddr (r_rd_ptr[ADDR_WIDTH-1:0]),
    .o_rdata (w_rdata)
  );

  assign bus.ready_output = r_accept_en && !w_full && !rst;
  assign bus.valid_output = !w_empty;
  assign bus.data_dest    = w_empty ? '0 : w_rdata;
  assign bus.count        = r_wr_ptr - r_rd_ptr;

endmodule
